// File: rtl/hist_multi.sv
// Multi-channel pixel histogram with ping-pong banks, saturating bins and a
// two-cycle registered readout port.
module hist_multi #(
    parameter int CH       = 3,
    parameter int PIX_W    = 8,
    parameter int BIN_BITS = 8,
    parameter int CNT_W    = 22
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CH*PIX_W-1:0]           pix_i,
    input  logic                          dv_i,
    input  logic                          vs_i,
    input  logic                          mode_i,
    input  logic                          clr_i,
    input  logic                          rd_strobe_i,
    input  logic [$clog2(CH)+BIN_BITS-1:0] rd_addr_i,
    output logic [CNT_W-1:0]              rd_data_o,
    output logic                          rd_ack_o,
    output logic                          frame_rdy_o,
    output logic                          drop_o
);

    // state    | meaning
    // S_CLEAR  | zeroing active bank, one bin per cycle (all channels)
    // S_WAIT_VS| bank clean, waiting for the first vsync edge
    // S_ACC    | accumulating; mode 0 swaps banks on vsync edge
    typedef enum logic [1:0] {S_CLEAR, S_WAIT_VS, S_ACC} state_t;

    localparam int NB  = 1 << BIN_BITS;
    localparam int CHW = $clog2(CH);
    localparam int CHI = (CH > 1) ? CHW : 1;
    localparam int AW  = CHW + BIN_BITS;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state, state_nxt;
    logic   swap;
    logic   bank_sel, mode_r, fresh, vs_q;
    logic   vs_rise, enter_clr, accept;
    logic [BIN_BITS-1:0] clr_cnt;

    logic                             s1_vld, s1_bank, s2_vld, s2_bank, s2_wr;
    logic [CH-1:0][BIN_BITS-1:0]      pix_bin, s1_bin, s2_bin;
    logic [CH-1:0][CNT_W-1:0]         s1_inc, s2_cnt, rd_val;

    logic                rd_p1, rd_bank, rd_ok, rd_ok_in;
    logic [CHI-1:0]      rd_ch, rd_ch_in;
    logic [BIN_BITS-1:0] rd_bin;

    assign vs_rise   = vs_i & ~vs_q;
    assign enter_clr = (state_nxt == S_CLEAR) && ((state != S_CLEAR) || clr_i);
    assign accept    = dv_i && (state == S_ACC) && !clr_i;
    assign s2_wr     = s2_vld && !clr_i;

    always_comb begin
        state_nxt = state;
        swap      = 1'b0;
        if (clr_i) begin
            state_nxt = S_CLEAR;
        end else begin
            case (state)
                S_CLEAR:   if (clr_cnt == '0) state_nxt = S_WAIT_VS;
                S_WAIT_VS: if (vs_rise) state_nxt = S_ACC;
                S_ACC: begin
                    if (vs_rise && !mode_r) begin
                        state_nxt = S_CLEAR;
                        swap      = 1'b1;
                    end
                end
                default:   state_nxt = S_CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_CLEAR;
            bank_sel    <= 1'b0;
            mode_r      <= 1'b0;
            fresh       <= 1'b1;
            vs_q        <= 1'b0;
            clr_cnt     <= '1;
            frame_rdy_o <= 1'b0;
            drop_o      <= 1'b0;
        end else begin
            state       <= state_nxt;
            vs_q        <= vs_i;
            fresh       <= 1'b0;
            frame_rdy_o <= swap;
            if (swap) bank_sel <= ~bank_sel;
            // mode is sampled once per clear so a frame never changes bank policy midway
            if (fresh || enter_clr) mode_r <= mode_i;
            if (enter_clr) clr_cnt <= '1;
            else if (state == S_CLEAR) clr_cnt <= clr_cnt - 1'b1;
            if (clr_i) drop_o <= 1'b0;
            else if (dv_i && (state != S_ACC)) drop_o <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_bank <= 1'b0;
            s1_bin  <= '0;
            s2_vld  <= 1'b0;
            s2_bank <= 1'b0;
            s2_bin  <= '0;
            s2_cnt  <= '0;
        end else begin
            s1_vld  <= accept;
            s1_bank <= bank_sel;
            s1_bin  <= pix_bin;
            s2_vld  <= s1_vld && !clr_i;
            s2_bank <= s1_bank;
            s2_bin  <= s1_bin;
            s2_cnt  <= s1_inc;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [CNT_W-1:0] mem [2][NB];
        logic [CNT_W-1:0] cur;

        assign pix_bin[c] = pix_i[c*PIX_W + PIX_W - BIN_BITS +: BIN_BITS];
        // back-to-back hits on one bin take the not-yet-written stage-2 count
        assign cur = (s2_vld && (s2_bank == s1_bank) && (s2_bin[c] == s1_bin[c]))
                     ? s2_cnt[c] : mem[s1_bank][s1_bin[c]];
        assign s1_inc[c] = (cur == CNT_MAX) ? cur : cur + 1'b1;
        assign rd_val[c] = mem[rd_bank][rd_bin];

        always_ff @(posedge clk) begin
            if (state == S_CLEAR) mem[bank_sel][clr_cnt] <= '0;
            if (s2_wr) mem[s2_bank][s2_bin[c]] <= s2_cnt[c];
        end
    end

    if (CHW > 0) begin : g_rd_ch
        assign rd_ch_in = rd_addr_i[AW-1 -: CHW];
    end else begin : g_rd_ch0
        assign rd_ch_in = '0;
    end
    assign rd_ok_in = int'(rd_ch_in) < CH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_p1     <= 1'b0;
            rd_bank   <= 1'b0;
            rd_ok     <= 1'b0;
            rd_ch     <= '0;
            rd_bin    <= '0;
            rd_ack_o  <= 1'b0;
            rd_data_o <= '0;
        end else begin
            rd_ack_o <= rd_p1;
            if (rd_strobe_i && !rd_p1) begin
                rd_p1   <= 1'b1;
                // bank is latched at request time so a swap cannot redirect the read
                rd_bank <= mode_r ? bank_sel : ~bank_sel;
                rd_ch   <= rd_ch_in;
                rd_bin  <= rd_addr_i[BIN_BITS-1:0];
                rd_ok   <= rd_ok_in;
            end else begin
                rd_p1 <= 1'b0;
            end
            if (rd_p1) rd_data_o <= rd_ok ? rd_val[rd_ch] : '0;
        end
    end

endmodule

// File: tb/tb_hist_multi.sv
// Directed bench for hist_multi: a default instance plus a CNT_W=4 instance
// sharing the same stimulus, checked against hand-computed bin counts.
module tb_hist_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] pix;
    logic        dv, vs, mode, clr, rd_strobe;
    logic [9:0]  rd_addr;
    logic [21:0] rd_data;
    logic [3:0]  rd_data_s;
    logic        rd_ack, frame_rdy, drop;
    logic        rd_ack_s, frame_rdy_s, drop_s;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hist_multi u_dut (
        .clk(clk), .rst_n(rst_n), .pix_i(pix), .dv_i(dv), .vs_i(vs),
        .mode_i(mode), .clr_i(clr), .rd_strobe_i(rd_strobe), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data), .rd_ack_o(rd_ack), .frame_rdy_o(frame_rdy), .drop_o(drop)
    );

    hist_multi #(.CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .pix_i(pix), .dv_i(dv), .vs_i(vs),
        .mode_i(mode), .clr_i(clr), .rd_strobe_i(rd_strobe), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data_s), .rd_ack_o(rd_ack_s), .frame_rdy_o(frame_rdy_s), .drop_o(drop_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_clear();
        repeat (270) tick();
    endtask

    task automatic vs_pulse(output logic fr);
        vs = 1'b1;
        tick();
        fr = frame_rdy;
        vs = 1'b0;
        tick();
    endtask

    task automatic stream(input logic [7:0] v, input int n);
        pix = {3{v}};
        dv  = 1'b1;
        repeat (n) tick();
        dv = 1'b0;
        repeat (3) tick();
    endtask

    task automatic rd(input logic [9:0] a, output logic [21:0] d, output logic [3:0] ds);
        rd_addr   = a;
        rd_strobe = 1'b1;
        tick();
        rd_strobe = 1'b0;
        tick();
        chk("rd_ack", rd_ack, 1);
        d  = rd_data;
        ds = rd_data_s;
        tick();
    endtask

    logic [9:0]  f1_addr [7] = '{10'h010, 10'h180, 10'h2FF, 10'h011, 10'h110, 10'h200, 10'h310};
    logic [21:0] f1_exp  [7] = '{22'd100, 22'd100, 22'd100, 22'd0, 22'd0, 22'd0, 22'd0};

    initial begin
        logic        fr;
        logic [21:0] d;
        logic [3:0]  ds;

        rst_n = 1'b0; pix = '0; dv = 1'b0; vs = 1'b0; mode = 1'b0; clr = 1'b0;
        rd_strobe = 1'b0; rd_addr = '0;
        repeat (3) tick();
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_ack", rd_ack, 0);
        chk("rst_frame_rdy", frame_rdy, 0);
        chk("rst_drop", drop, 0);
        rst_n = 1'b1;
        wait_clear();
        chk("drop_idle", drop, 0);

        // frame 1 (bank A): 100 pixels of R=10 G=80 B=FF
        vs_pulse(fr);
        chk("first_vs_no_frame_rdy", fr, 0);
        pix = {8'hFF, 8'h80, 8'h10};
        dv  = 1'b1;
        repeat (100) tick();
        dv = 1'b0;
        repeat (3) tick();
        vs_pulse(fr);
        chk("frame_rdy_f1", fr, 1);
        chk("frame_rdy_one_cycle", frame_rdy, 0);
        for (int i = 0; i < 7; i++) begin
            rd(f1_addr[i], d, ds);
            chk($sformatf("f1_bin_%03h", f1_addr[i]), d, f1_exp[i]);
        end
        wait_clear();

        // frame 2 (bank B): 1000 identical pixels
        vs_pulse(fr);
        stream(8'h42, 1000);
        vs_pulse(fr);
        chk("frame_rdy_f2", fr, 1);
        rd(10'h042, d, ds); chk("same_ch0", d, 1000);
        rd(10'h242, d, ds); chk("same_ch2", d, 1000);
        rd(10'h043, d, ds); chk("same_neighbour", d, 0);
        wait_clear();

        // frame 3 (bank A): alternating values, then 20 pixels for saturation
        vs_pulse(fr);
        dv = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            pix = (i % 2 == 1) ? {3{8'hA0}} : {3{8'h20}};
            tick();
        end
        dv = 1'b0;
        stream(8'h33, 20);

        // read issued in the swap cycle must return the pre-swap bank (frame 2)
        rd_addr   = 10'h042;
        rd_strobe = 1'b1;
        vs        = 1'b1;
        tick();
        chk("frame_rdy_f3", frame_rdy, 1);
        rd_strobe = 1'b0;
        vs        = 1'b0;
        tick();
        chk("swap_rd_ack", rd_ack, 1);
        chk("swap_rd_old_frame", rd_data, 1000);
        tick();
        rd(10'h120, d, ds); chk("alt_20", d, 500);
        rd(10'h1A0, d, ds); chk("alt_A0", d, 500);
        rd(10'h033, d, ds); chk("cnt20_wide", d, 20); chk("cnt20_sat4", ds, 15);
        rd(10'h042, d, ds); chk("new_bank_42", d, 0);

        // drops: pixels in CLEAR and in WAIT_VS are discarded
        pix = {3{8'h55}};
        dv  = 1'b1;
        repeat (3) tick();
        dv = 1'b0;
        tick();
        chk("drop_in_clear", drop, 1);
        wait_clear();
        dv = 1'b1;
        repeat (5) tick();
        dv = 1'b0;
        tick();
        vs_pulse(fr);
        stream(8'h66, 10);
        vs_pulse(fr);
        chk("frame_rdy_f4", fr, 1);
        rd(10'h055, d, ds); chk("dropped_not_counted", d, 0);
        rd(10'h066, d, ds); chk("after_drop_counted", d, 10);
        chk("drop_sticky", drop, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("drop_cleared", drop, 0);

        // clr_i and vsync edge together: clear wins, no frame_rdy
        wait_clear();
        vs_pulse(fr);
        mode = 1'b1;
        clr  = 1'b1;
        vs   = 1'b1;
        tick();
        chk("clr_vs_no_frame_rdy", frame_rdy, 0);
        clr = 1'b0;
        vs  = 1'b0;
        tick();
        chk("clr_vs_no_frame_rdy_late", frame_rdy, 0);

        // running accumulate across three frames
        wait_clear();
        vs_pulse(fr);
        stream(8'h77, 50);
        vs_pulse(fr);
        chk("mode1_no_frame_rdy", fr, 0);
        rd(10'h277, d, ds); chk("mode1_after_1", d, 50);
        stream(8'h77, 50);
        vs_pulse(fr);
        stream(8'h77, 50);
        vs_pulse(fr);
        rd(10'h277, d, ds); chk("mode1_after_3_ch2", d, 150);
        rd(10'h077, d, ds); chk("mode1_after_3_ch0", d, 150);

        // reset during an outstanding read
        clr = 1'b1;
        tick();
        clr = 1'b0;
        dv  = 1'b1;
        tick();
        dv = 1'b0;
        chk("drop_before_rst", drop, 1);
        rd_addr   = 10'h077;
        rd_strobe = 1'b1;
        tick();
        rd_strobe = 1'b0;
        rst_n     = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_mid_rd_ack", rd_ack, 0);
        end
        chk("rst_mid_rd_data", rd_data, 0);
        chk("rst_mid_drop", drop, 0);
        chk("rst_mid_frame_rdy", frame_rdy, 0);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("rst_release_no_ack", rd_ack, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
